// File: rtl/mult4_sched_pkg.sv
// mult4_sched_pkg
// Shared types and helpers for the round-robin multiplier scheduler.
//   OPW    : operand width of the shared 4x4 multiplier
//   PRODW  : product width (never truncated)
//   IDMAXW : storage width for requester IDs (covers up to 8 requesters)
//   iss_t  : issue-stage payload {x, y, id}
//   res_t  : result-stage payload {prod, id}
//   rr_next: (ptr + idx) mod nreq, used for both the arbiter scan order and
//            the pointer advance after an accept
package mult4_sched_pkg;

    localparam int OPW    = 4;
    localparam int PRODW  = 8;
    localparam int IDMAXW = 3;

    typedef struct packed {
        logic [OPW-1:0]    x;
        logic [OPW-1:0]    y;
        logic [IDMAXW-1:0] id;
    } iss_t;

    typedef struct packed {
        logic [PRODW-1:0]  prod;
        logic [IDMAXW-1:0] id;
    } res_t;

    function automatic int rr_next(input int ptr, input int idx, input int nreq);
        return (ptr + idx) % nreq;
    endfunction

endpackage

// File: rtl/main.sv
// main
// Existing 4x4 unsigned combinational multiplier shared by the scheduler.
//   x : 4-bit operand
//   y : 4-bit operand
//   o : 8-bit unsigned product
module main (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] o
);

    assign o = {4'b0000, x} * {4'b0000, y};

endmodule

// File: rtl/rr_arbiter_nreq.sv
// rr_arbiter_nreq
// Purely combinational round-robin arbiter: grants the first asserted request
// found scanning from ptr_i upward with wraparound.
//   req_i   : per-requester request
//   ptr_i   : index with highest priority this cycle
//   grant_o : one-hot grant (all zero when no request)
//   gidx_o  : binary index of the granted requester (0 when idle)
module rr_arbiter_nreq
    import mult4_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  gidx_o
);

    logic found;
    int   idx;

    always_comb begin
        grant_o = '0;
        gidx_o  = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_next(int'(ptr_i), k, NREQ);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                gidx_o       = IDW'(idx);
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult4_rr_scheduler.sv
// mult4_rr_scheduler
// Shares one 4x4 multiplier between NREQ requesters. An issue register feeds
// the multiplier and a result register captures its output, so at most two
// products are in flight.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (req_ready is one-hot or 0)
//   req_x/req_y         : packed operands, requester i at [4i+3:4i]
//   rsp_valid/rsp_ready : response handshake toward the single consumer
//   rsp_id/rsp_prod     : originating requester and its 8-bit product
module mult4_rr_scheduler
    import mult4_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*4-1:0] req_x,
    input  logic [NREQ*4-1:0] req_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [PRODW-1:0]  rsp_prod
);

    logic             iss_v_q, iss_v_d;
    logic             res_v_q, res_v_d;
    iss_t             iss_q, iss_d;
    res_t             res_q, res_d;
    logic [IDW-1:0]   rr_q, rr_d;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gidx;
    logic [PRODW-1:0] mul_o;
    logic             res_en, iss_en, accept;

    rr_arbiter_nreq #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_q),
        .grant_o (grant),
        .gidx_o  (gidx)
    );

    main u_mul (
        .x (iss_q.x),
        .y (iss_q.y),
        .o (mul_o)
    );

    // A stage may advance when it is empty or the stage after it is moving.
    assign res_en = !res_v_q | rsp_ready;
    assign iss_en = !iss_v_q | res_en;

    // rst_n gates the grant so nothing is accepted while reset is held.
    assign req_ready = grant & {NREQ{iss_en & rst_n}};
    assign accept    = |req_ready;

    always_comb begin
        iss_v_d = iss_v_q;
        res_v_d = res_v_q;
        iss_d   = iss_q;
        res_d   = res_q;
        rr_d    = rr_q;
        if (res_en) begin
            res_d.prod = mul_o;
            res_d.id   = iss_q.id;
            res_v_d    = iss_v_q;
        end
        if (iss_en) begin
            iss_v_d = accept;
        end
        if (accept) begin
            iss_d.x  = req_x[int'(gidx)*OPW +: OPW];
            iss_d.y  = req_y[int'(gidx)*OPW +: OPW];
            iss_d.id = IDMAXW'(gidx);
            rr_d     = IDW'(rr_next(int'(gidx), 1, NREQ));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_v_q <= 1'b0;
            res_v_q <= 1'b0;
            iss_q   <= '0;
            res_q   <= '0;
            rr_q    <= '0;
        end else begin
            iss_v_q <= iss_v_d;
            res_v_q <= res_v_d;
            iss_q   <= iss_d;
            res_q   <= res_d;
            rr_q    <= rr_d;
        end
    end

    assign rsp_valid = res_v_q;
    assign rsp_prod  = res_q.prod;
    assign rsp_id    = IDW'(res_q.id);

endmodule

// File: tb/tb_mult4_rr_scheduler.sv
// tb_mult4_rr_scheduler
// Directed bench for mult4_rr_scheduler. Stimulus pushes hand-computed
// responses into a queue; a monitor pops and compares on every response
// transfer.
module tb_mult4_rr_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_x;
    logic [15:0] req_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_prod;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] prod;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    mult4_rr_scheduler #(.NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one value and keeps the pass/total counters.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Presents one request from requester r, waits (bounded) for the accept
    // and records the expected response. Entered and left at posedge+1.
    task automatic applyStimulus(input int r, input logic [3:0] x, input logic [3:0] y,
                                 input logic [7:0] prod);
        int   n;
        logic ok;
        exp_t e;
        req_valid[r]       = 1'b1;
        req_x[r*4 +: 4]    = x;
        req_y[r*4 +: 4]    = y;
        n  = 0;
        ok = 1'b0;
        while (n < 20 && !ok) begin
            @(negedge clk);
            if (req_ready[r]) ok = 1'b1;
            else n++;
        end
        checkOutput("accept_seen", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if (ok) begin
            e.id   = 2'(r);
            e.prod = prod;
            exp_q.push_back(e);
        end
        req_valid[r] = 1'b0;
    endtask

    // Lets outstanding responses drain, then confirms none are missing.
    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: every response transfer must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_rsp: got id %0d prod %0d, expected no response",
                         rsp_id, rsp_prod);
            end else begin
                e = exp_q.pop_front();
                checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                checkOutput("rsp_prod", 32'(rsp_prod), 32'(e.prod));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;

        // Reset state, with requests present to confirm req_ready is gated.
        #1;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #2;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("reset_rsp_prod", 32'(rsp_prod), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sparse: only requester 3 with rr=0, then requesters 0 and 1.
        applyStimulus(3, 4'd2, 4'd5, 8'd10);
        req_x[3:0] = 4'd4;  req_y[3:0] = 4'd4;
        req_x[7:4] = 4'd6;  req_y[7:4] = 4'd7;
        req_valid  = 4'b0011;
        @(negedge clk);
        checkOutput("sparse_grant0", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        e.id = 2'd0; e.prod = 8'd16; exp_q.push_back(e);
        @(negedge clk);
        checkOutput("sparse_grant1", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1;
        e.id = 2'd1; e.prod = 8'd42; exp_q.push_back(e);
        req_valid = '0;
        waitDrain();

        // Single request with latency check.
        applyStimulus(2, 4'd13, 4'd11, 8'd143);
        @(negedge clk);
        checkOutput("lat_after_edge1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_after_edge2", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        waitDrain();

        // Backpressure: two products held, third requester must be refused.
        rsp_ready = 1'b0;
        applyStimulus(0, 4'd15, 4'd15, 8'd225);
        applyStimulus(1, 4'd7, 4'd9, 8'd63);
        req_valid[2]   = 1'b1;
        req_x[11:8]    = 4'd1;
        req_y[11:8]    = 4'd1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rsp_prod", 32'(rsp_prod), 32'd225);
            checkOutput("bp_rsp_id", 32'(rsp_id), 32'd0);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_first_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        checkOutput("bp_second_valid", 32'(rsp_valid), 32'd1);
        checkOutput("bp_second_prod", 32'(rsp_prod), 32'd63);
        @(posedge clk);
        #1;
        waitDrain();

        // Reset mid-flight with both stages full.
        rsp_ready = 1'b0;
        applyStimulus(0, 4'd3, 4'd3, 8'd9);
        applyStimulus(1, 4'd5, 4'd5, 8'd25);
        #2;
        req_valid = 4'hF;
        rst_n     = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("midrst_rsp_prod", 32'(rsp_prod), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;

        // Round-robin with all requesters valid; rr must restart at 0.
        for (int i = 0; i < 4; i++) begin
            req_x[i*4 +: 4] = 4'(i + 1);
            req_y[i*4 +: 4] = 4'd3;
        end
        e.id = 2'd0; e.prod = 8'd3;  exp_q.push_back(e);
        e.id = 2'd1; e.prod = 8'd6;  exp_q.push_back(e);
        e.id = 2'd2; e.prod = 8'd9;  exp_q.push_back(e);
        e.id = 2'd3; e.prod = 8'd12; exp_q.push_back(e);
        e.id = 2'd0; e.prod = 8'd3;  exp_q.push_back(e);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        waitDrain();

        // Every operand pair through requester 1.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                applyStimulus(1, 4'(x), 4'(y), 8'(x * y));
            end
        end
        waitDrain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mult4_rr_scheduler.md
# mult4_rr_scheduler

Round-robin scheduler that shares one instance of the existing 4x4 combinational multiplier (module `main`, 4-bit `x`/`y`, 8-bit `o`) between NREQ requesters. Requests use valid/ready handshakes. A two-stage pipeline brackets the multiplier: an issue register feeds it and a result register captures its output, so the combinational path is fully registered. The block sits between operand-producing clients and a single response consumer that receives each product tagged with the originating requester ID.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), requester ID width (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_x  in  NREQ*4  operand x, requester i at [4i+3:4i]
- req_y  in  NREQ*4  operand y, same packing
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  IDW  requester index of the product
- rsp_prod  out  8  unsigned product x*y

## Operation
- Stage enables:
  - res_en = !res_v | rsp_ready
  - iss_en = !iss_v | res_en
- Arbitration: round-robin over req_valid, starting at pointer rr (reset 0).
  - grant = first asserted req_valid[i] scanning i = rr, rr+1, …, wrapping NREQ-1 → 0.
  - req_ready[i] = grant[i] & iss_en (combinational from req_valid, rr, pipeline state).
  - Requesters must not make req_valid depend on req_ready.
- Accept (req_valid[i] & req_ready[i]):
  - issue register loads {x_i, y_i, id=i}; iss_v ← 1.
  - rr ← (i+1) mod NREQ.
  - When no accept occurs, rr holds.
- Issue register → `main` → result register:
  - When res_en, the result register loads {o, iss_id} and res_v ← iss_v.
  - When iss_en with no accept, iss_v ← 0.
- Response outputs: rsp_valid = res_v, rsp_prod/rsp_id come from the result register. Transfer completes on rsp_valid & rsp_ready.
- Stability: while rsp_valid & !rsp_ready, rsp_prod and rsp_id hold stable, both stages stall, and req_ready = 0 whenever the issue register is also full.
- Width rules: product is 8-bit unsigned, never truncated; 15*15 = 225.
- Reset (rst_n low, any time, including mid-operation):
  - iss_v, res_v, rr, and all data registers ← 0 immediately.
  - In-flight operations are dropped with no response.
  - req_ready = 0 while rst_n is low.

## Timing
- Latency: a request accepted at rising edge t produces rsp_valid high in the cycle after edge t+1 (2 edges), provided rsp_ready was not stalling.
- Throughput: one accept and one response per cycle when rsp_ready is held high.
- Simultaneous events:
  - A response transfer and a new accept in the same cycle are both legal; the pipeline advances.
  - Capacity is two outstanding products maximum.
- Output values during reset: req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_prod = 0.
- Fairness: with all NREQ requesters continuously valid and rsp_ready = 1, grants rotate 0,1,…,NREQ-1,0,…; no requester waits more than NREQ-1 accepts.

## Structure
- Package mult4_sched_pkg:
  - OPW = 4 and PRODW = 8.
  - Packed struct iss_t {x, y, id}.
  - Packed struct res_t {prod, id}.
  - Helper function rr_next(ptr, idx).
- Sub-module rr_arbiter_nreq: purely combinational one-hot grant from (req, ptr).
- Multiplier: existing `main` instantiated unmodified; no arithmetic inside the scheduler.

## Test plan
- Single request: requester 2 sends x=13, y=11, rsp_ready=1 → rsp_valid 2 edges after accept, rsp_prod=143, rsp_id=2.
- Round-robin: all 4 requesters valid continuously, requester i supplying x=i+1, y=3, rsp_ready=1 → rsp_id sequence 0,1,2,3,0; products 3,6,9,12,3.
- Backpressure: two accepts (x=15/y=15, then x=7/y=9), then rsp_ready=0 for 5 cycles → rsp_prod holds 225, req_ready stays 0, no third accept. After rsp_ready=1 → 225 then 63 on consecutive cycles.
- Sparse requests: only requester 3 valid, rr=0 → requester 3 granted and rr becomes 0. Then requesters 0 and 1 valid → grant 0 first.
- Reset mid-flight: assert rst_n low with both stages full → rsp_valid=0 and req_ready=0 immediately (asynchronous). After release, the next request is served with rr=0 and no stale response appears.
- Exhaustive operands: all 256 (x,y) pairs through requester 1 → every rsp_prod == x*y.
